// File: rtl/axi_ring_reader.sv
// Drains a ring of DATA_WIDTH/8-byte slots: one single-beat AXI read per slot, re-emitted on AXIS.
// Optional rresp error counter on rd_err_count with RING_READER_ERR_CNT_EN.
module axi_ring_reader #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int ADDR_WIDTH = 34,
  parameter int ID_WIDTH   = 6,
  parameter int RING_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ring_base_addr,
  input  logic                  ring_base_addr_valid,
  input  logic [31:0]           wr_ptr,
  output logic [31:0]           rd_ptr,
`ifdef RING_READER_ERR_CNT_EN
  output logic [15:0]           rd_err_count,
`endif
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  localparam int PTR_W      = (RING_DEPTH > 1) ? $clog2(RING_DEPTH) : 1;
  localparam int SLOT_BYTES = DATA_WIDTH / 8;
  localparam int SIZE       = $clog2(KEEP_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R,
    OUT
  } state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
`ifdef RING_READER_ERR_CNT_EN
  logic [15:0]           err_q, err_d;
`endif

  logic                  empty;
  logic [PTR_W-1:0]      rd_ptr_nxt;
  logic [ADDR_WIDTH-1:0] slot_addr;
  logic                  unused_ok;

  assign empty      = (32'(rd_ptr_q) == wr_ptr);
  assign rd_ptr_nxt = (rd_ptr_q == PTR_W'(RING_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
  assign slot_addr  = base_q + ADDR_WIDTH'(rd_ptr_q) * ADDR_WIDTH'(SLOT_BYTES);
  assign unused_ok  = ^{m_axi_rid, m_axi_rlast};

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    base_d      = base_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
`ifdef RING_READER_ERR_CNT_EN
    err_d       = err_q;
`endif
    // A base pulse outside IDLE waits here; the newest pulse wins.
    if (ring_base_addr_valid) begin
      pend_d      = 1'b1;
      pend_addr_d = ring_base_addr;
    end
    unique case (state_q)
      IDLE: begin
        if (ring_base_addr_valid || pend_q) begin
          base_d   = ring_base_addr_valid ? ring_base_addr : pend_addr_q;
          rd_ptr_d = '0;
          pend_d   = 1'b0;
        end else if (!empty) begin
          araddr_d  = slot_addr;
          arvalid_d = 1'b1;
          state_d   = AR;
        end
      end
      AR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = R;
        end
      end
      R: begin
        if (m_axi_rvalid && rready_q) begin
          rready_d = 1'b0;
          if (m_axi_rresp == 2'b00) begin
            tdata_d  = m_axi_rdata;
            tvalid_d = 1'b1;
            state_d  = OUT;
          end else begin
            rd_ptr_d = rd_ptr_nxt;
            state_d  = IDLE;
`ifdef RING_READER_ERR_CNT_EN
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
`endif
          end
        end
      end
      OUT: begin
        if (m_axis_tready) begin
          tvalid_d = 1'b0;
          rd_ptr_d = rd_ptr_nxt;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      base_q      <= '0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
`ifdef RING_READER_ERR_CNT_EN
      err_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      base_q      <= base_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
`ifdef RING_READER_ERR_CNT_EN
      err_q       <= err_d;
`endif
    end
  end

  assign rd_ptr        = 32'(rd_ptr_q);
`ifdef RING_READER_ERR_CNT_EN
  assign rd_err_count  = err_q;
`endif
  assign m_axi_arid    = '0;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = '1;
  assign m_axis_tlast  = 1'b1;
  assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_axi_ring_reader.sv
// Bench for axi_ring_reader: vector table of slot reads plus a randomized run
// against a slot-arithmetic ring model.
module tb_axi_ring_reader;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int AW = 34;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ring_base_addr;
  logic          ring_base_addr_valid;
  logic [31:0]   wr_ptr;
  logic [31:0]   rd_ptr;
  logic [15:0]   rd_err_count;
  logic [IW-1:0] m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arlock;
  logic [3:0]    m_axi_arcache;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [IW-1:0] m_axi_rid;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;

  always #5 clk = ~clk;

  axi_ring_reader dut (
    .clk(clk),
    .rst(rst),
    .ring_base_addr(ring_base_addr),
    .ring_base_addr_valid(ring_base_addr_valid),
    .wr_ptr(wr_ptr),
    .rd_ptr(rd_ptr),
`ifdef RING_READER_ERR_CNT_EN
    .rd_err_count(rd_err_count),
`endif
    .m_axi_arid(m_axi_arid),
    .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst),
    .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache),
    .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid),
    .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
  );

`ifndef RING_READER_ERR_CNT_EN
  assign rd_err_count = 16'd0;
`endif

  int n_chk = 0;
  int n_bad = 0;
  int exp_err = 0;

  typedef struct {
    bit          load;
    logic [33:0] base;
    int          wr;
    logic [1:0]  resp;
    int          ar_dly;
    int          r_dly;
    int          t_dly;
    logic [33:0] pulse;
    logic [33:0] exp_addr;
    bit          exp_out;
    int          exp_rd;
    int          idle;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic vec_t mk(bit ld, logic [33:0] b, int w, logic [1:0] rs,
                              int ad, int rd, int td, logic [33:0] pl,
                              logic [33:0] ea, bit eo, int er, int idl);
    vec_t v;
    v.load = ld; v.base = b; v.wr = w; v.resp = rs;
    v.ar_dly = ad; v.r_dly = rd; v.t_dly = td; v.pulse = pl;
    v.exp_addr = ea; v.exp_out = eo; v.exp_rd = er; v.idle = idl;
    return v;
  endfunction

  task automatic pulse_base(input logic [33:0] a);
    ring_base_addr       = a;
    ring_base_addr_valid = 1'b1;
    tick();
    ring_base_addr_valid = 1'b0;
  endtask

  task automatic wait_ar(output bit ok);
    int t;
    t = 0;
    while (!m_axi_arvalid && t < 40) begin
      tick();
      t++;
    end
    ok = m_axi_arvalid;
    if (!ok) begin
      n_chk++;
      n_bad++;
      $display("FAIL ar_timeout act=0 exp=1");
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [DW-1:0] d;
    bit ok;
    if (v.load) pulse_base(v.base);
    wr_ptr = v.wr;
    d = rand_data();
    wait_ar(ok);
    if (!ok) return;
    chk("araddr", m_axi_araddr, v.exp_addr);
    chk("arlen", m_axi_arlen, 0);
    chk("arsize", m_axi_arsize, 6);
    chk("arburst", m_axi_arburst, 1);
    chk("arid", m_axi_arid, 0);
    if (v.pulse != 0) pulse_base(v.pulse);
    repeat (v.ar_dly) tick();
    chk("araddr_hold", m_axi_araddr, v.exp_addr);
    chk("arvalid_hold", m_axi_arvalid, 1);
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    chk("arvalid_drop", m_axi_arvalid, 0);
    chk("rready_up", m_axi_rready, 1);
    repeat (v.r_dly) tick();
    m_axi_rvalid = 1'b1;
    m_axi_rdata  = d;
    m_axi_rresp  = v.resp;
    m_axi_rid    = IW'($urandom);
    tick();
    m_axi_rvalid = 1'b0;
    chk("rready_drop", m_axi_rready, 0);
    if (v.resp != 0) exp_err++;
    if (v.exp_out) begin
      chk("tvalid", m_axis_tvalid, 1);
      chk("tdata", m_axis_tdata, d);
      chk("tlast", m_axis_tlast, 1);
      chk("tkeep", m_axis_tkeep, {KW{1'b1}});
      for (int i = 0; i < v.t_dly; i++) begin
        tick();
        chk("tvalid_hold", m_axis_tvalid, 1);
        chk("tdata_hold", m_axis_tdata, d);
        chk("no_ar_in_out", m_axi_arvalid, 0);
      end
      m_axis_tready = 1'b1;
      tick();
      m_axis_tready = 1'b0;
      chk("tvalid_drop", m_axis_tvalid, 0);
    end else begin
      chk("err_no_tvalid", m_axis_tvalid, 0);
    end
    chk("rd_ptr", rd_ptr, v.exp_rd);
`ifdef RING_READER_ERR_CNT_EN
    chk("rd_err_count", rd_err_count, exp_err);
`endif
    for (int i = 0; i < v.idle; i++) begin
      tick();
      chk("idle_arvalid", m_axi_arvalid, 0);
    end
  endtask

  initial begin
    logic [33:0] m_base;
    int          m_rd;
    int          wr_cur;
    bit          ok;
    vec_t        v;

    // slot reads from base 0x1000, including error beats and stalls
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 34'h1000, 1, 1, 0));
    tbl.push_back(mk(0, 0, 2, 0, 3, 2, 0, 0, 34'h1040, 1, 2, 0));
    tbl.push_back(mk(0, 0, 3, 0, 1, 0, 1, 0, 34'h1080, 1, 3, 0));
    tbl.push_back(mk(0, 0, 4, 2, 0, 1, 0, 0, 34'h10C0, 0, 4, 0));
    tbl.push_back(mk(0, 0, 5, 0, 0, 0, 10, 0, 34'h1100, 1, 5, 0));
    tbl.push_back(mk(0, 0, 6, 1, 2, 0, 0, 0, 34'h1140, 0, 6, 0));
    for (int i = 6; i < 31; i++)
      tbl.push_back(mk(0, 0, 31, 0, i % 3, i % 2, 0, 0,
                       34'h1000 + 34'(i) * 34'd64, 1, i + 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 34'h17C0, 1, 0, 5));
    tbl.push_back(mk(0, 0, 1, 0, 2, 0, 0, 34'h8000, 34'h1000, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 34'h8000, 1, 1, 0));
    tbl.push_back(mk(1, 34'h3_FFFF_FFC0, 2, 0, 0, 0, 0, 0,
                     34'h3_FFFF_FFC0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 2, 0, 0, 0, 0, 0, 34'h0, 1, 2, 0));

    rst = 1'b1;
    ring_base_addr = '0;
    ring_base_addr_valid = 1'b0;
    wr_ptr = 0;
    m_axi_arready = 1'b0;
    m_axi_rid = '0;
    m_axi_rdata = '0;
    m_axi_rresp = 2'b00;
    m_axi_rlast = 1'b1;
    m_axi_rvalid = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_rd_ptr", rd_ptr, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_err", rd_err_count, 0);

    pulse_base(34'h1000);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("empty_arvalid", m_axi_arvalid, 0);
      chk("empty_tvalid", m_axis_tvalid, 0);
      chk("empty_rd_ptr", rd_ptr, 0);
    end

    foreach (tbl[i]) run_vec(tbl[i]);

    // randomized run against the ring model
    m_base = 34'h3_FFFF_FFC0;
    m_rd   = 2;
    wr_cur = 2;
    for (int n = 0; n < 60; n++) begin
      v = mk(0, 0, 0, 0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), 0, 0, 0, 0, 0);
      if (m_rd == wr_cur && $urandom_range(0, 5) == 0) begin
        v.load = 1;
        v.base = {$urandom_range(0, 3), $urandom} & ~34'h3F;
        m_base = v.base;
        m_rd   = 0;
      end
      if (m_rd == wr_cur) wr_cur = (m_rd + $urandom_range(1, 5)) % 32;
      v.wr       = wr_cur;
      v.resp     = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      v.exp_addr = m_base + 34'(m_rd) * 34'd64;
      v.exp_out  = (v.resp == 2'b00);
      m_rd       = (m_rd + 1) % 32;
      v.exp_rd   = m_rd;
      run_vec(v);
    end

    // reset while a read is outstanding
    wr_ptr = (m_rd + 1) % 32;
    wait_ar(ok);
    if (ok) begin
      m_axi_arready = 1'b1;
      tick();
      m_axi_arready = 1'b0;
      chk("pre_rst_rready", m_axi_rready, 1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_arvalid", m_axi_arvalid, 0);
    chk("mid_rst_rready", m_axi_rready, 0);
    chk("mid_rst_tvalid", m_axis_tvalid, 0);
    chk("mid_rst_rd_ptr", rd_ptr, 0);
    chk("mid_rst_tdata", m_axis_tdata, 0);
    wr_ptr = 1;
    wait_ar(ok);
    if (ok) chk("post_rst_araddr", m_axi_araddr, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
